// File: rtl/hcordic_iter_ctrl.sv
// Iterative hyperbolic CORDIC: one micro-rotation per clock, shifts 4 and 13 repeated.
// Ports: clk, rst, in_valid/in_ready, mode, x/y/z_in, out_valid/out_ready, x/y/z_out, busy.
module hcordic_iter_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int N_ITER     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [DATA_WIDTH-1:0] z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic signed [DATA_WIDTH-1:0] z_out,
  output logic                         busy
);

  localparam int SW = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0]                sh;
  logic                         rep;
  logic                         mode_q;
  logic signed [DATA_WIDTH-1:0] xr, yr, zr;
  logic signed [DATA_WIDTH-1:0] tab [0:N_ITER];
  logic signed [DATA_WIDTH-1:0] t_cur, x_sh, y_sh;
  logic                         d_pos, rpt_pt, last;

  // atanh(2^-i) in Q(FRAC_BITS); low indices are held at Q16 and rescaled,
  // high indices use atanh(x) ~= x, exact once x^3/3 falls below one LSB.
  function automatic logic [DATA_WIDTH-1:0] atab(input int i);
    logic [63:0] v;
    v = 64'd0;
    if (i >= 8) begin
      if (FRAC_BITS >= i) v = 64'd1 << (FRAC_BITS - i);
    end else begin
      case (i)
        1: v = 64'd35999;
        2: v = 64'd16739;
        3: v = 64'd8235;
        4: v = 64'd4101;
        5: v = 64'd2049;
        6: v = 64'd1024;
        7: v = 64'd512;
        default: v = 64'd0;
      endcase
      if (FRAC_BITS >= 16) v = v << (FRAC_BITS - 16);
      else v = (v + (64'd1 << (15 - FRAC_BITS))) >> (16 - FRAC_BITS);
    end
    return v[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k <= N_ITER; k++) tab[k] = atab(k);
  end

  assign t_cur  = tab[sh];
  assign x_sh   = xr >>> sh;
  assign y_sh   = yr >>> sh;
  assign d_pos  = mode_q ? yr[DATA_WIDTH-1] : !zr[DATA_WIDTH-1];
  // First visit of shift 4 or 13: run it again before advancing.
  assign rpt_pt = ((int'(sh) == 4) || (int'(sh) == 13)) && !rep;
  assign last   = (int'(sh) == N_ITER) && !rpt_pt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      mode_q <= 1'b0;
      sh     <= '0;
      rep    <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        xr     <= x_in;
        yr     <= y_in;
        zr     <= z_in;
        mode_q <= mode;
        sh     <= SW'(1);
        rep    <= 1'b0;
      end
    end else if (state == RUN) begin
      if (d_pos) begin
        xr <= xr + y_sh;
        yr <= yr + x_sh;
        zr <= zr - t_cur;
      end else begin
        xr <= xr - y_sh;
        yr <= yr - x_sh;
        zr <= zr + t_cur;
      end
      if (rpt_pt) begin
        rep <= 1'b1;
      end else begin
        rep <= 1'b0;
        if (!last) sh <= sh + SW'(1);
      end
    end
  end

  assign x_out = xr;
  assign y_out = yr;
  assign z_out = zr;

endmodule

// File: tb/tb_hcordic_iter_ctrl.sv
// Testbench for hcordic_iter_ctrl: spec vectors, corner sequences, random ops.
// Reference model walks the shift schedule with plain integer arithmetic.
module tb_hcordic_iter_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            mode;
  logic signed [31:0] x_in, y_in, z_in;
  logic            out_valid;
  logic            out_ready;
  logic signed [31:0] x_out, y_out, z_out;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  hcordic_iter_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    int x, y, z;
    int ex, ey, ez;
    int tol;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint exp,
                         input longint tol);
    longint d;
    n_cmp++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  function automatic void model(input bit m, input int xi, yi, zi,
                                output int xo, yo, zo);
    int sched[$];
    int t [0:16];
    int x, y, z, xn, yn, i;
    t = '{0, 35999, 16739, 8235, 4101, 2049, 1024, 512,
          256, 128, 64, 32, 16, 8, 4, 2, 1};
    for (int k = 1; k <= 16; k++) begin
      sched.push_back(k);
      if (k == 4 || k == 13) sched.push_back(k);
    end
    x = xi; y = yi; z = zi;
    foreach (sched[k]) begin
      i = sched[k];
      if (m ? (y < 0) : (z >= 0)) begin
        xn = x + (y >>> i); yn = y + (x >>> i); z = z - t[i];
      end else begin
        xn = x - (y >>> i); yn = y - (x >>> i); z = z + t[i];
      end
      x = xn; y = yn;
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand set, scrambles inputs during RUN, waits for out_valid.
  task automatic run_op(input bit m, input int xi, yi, zi, input bit release_out,
                        output int xo, yo, zo, output int lat);
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    mode = m; x_in = xi; y_in = yi; z_in = zi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mode = ~m;
    x_in = $urandom; y_in = $urandom; z_in = $urandom;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
    xo = x_out; yo = y_out; zo = z_out;
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  vec_t vecs[3];
  int xo, yo, zo, lat;
  int mx, my, mz;
  int hx, hy, hz;
  bit bad;
  int rises[$];

  initial begin
    vecs[0] = '{0, 79135, 0, 0, 65536, 0, 0, 8};
    vecs[1] = '{0, 79135, 0, 32768, 73900, 34151, 0, 16};
    vecs[2] = '{1, 131072, 65536, 0, 94006, 0, 35999, 16};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    x_in = 0; y_in = 0; z_in = 0;
    tick(); tick();
    rst = 1'b0;

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset xyz", x_out | y_out | z_out, 0);

    foreach (vecs[v]) begin
      run_op(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, 1'b1, xo, yo, zo, lat);
      model(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, mx, my, mz);
      chk($sformatf("vec%0d latency", v), lat, 18);
      chk_tol($sformatf("vec%0d x", v), xo, vecs[v].ex, vecs[v].tol);
      chk_tol($sformatf("vec%0d y", v), yo, vecs[v].ey, vecs[v].tol);
      chk_tol($sformatf("vec%0d z", v), zo, vecs[v].ez, vecs[v].tol);
      chk($sformatf("vec%0d model xyz", v),
          (xo == mx && yo == my && zo == mz), 1);
      chk($sformatf("vec%0d idle after hs", v), in_ready, 1);
    end

    // Backpressure with stray in_valid pulses while holding the result.
    run_op(0, 79135, 0, 32768, 1'b0, hx, hy, hz, lat);
    chk("bp latency", lat, 18);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      mode = $urandom; x_in = $urandom; y_in = $urandom; z_in = $urandom;
      tick();
      if (x_out != hx || y_out != hy || z_out != hz) bad = 1'b1;
      if (in_ready || !out_valid || busy) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp hold stable", bad, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);

    // Reset at step 7 of a run.
    mode = 0; x_in = 79135; y_in = 0; z_in = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("mid-run busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst run in_ready", in_ready, 1);
    chk("rst run out_valid", out_valid, 0);
    chk("rst run busy", busy, 0);
    chk("rst run xyz", x_out | y_out | z_out, 0);
    run_op(0, 79135, 0, 0, 1'b1, xo, yo, zo, lat);
    chk("post rst latency", lat, 18);
    chk_tol("post rst x", xo, 65536, 8);

    // Reset coinciding with the output handshake.
    run_op(1, 131072, 65536, 0, 1'b0, xo, yo, zo, lat);
    out_ready = 1'b1; rst = 1'b1;
    tick();
    out_ready = 1'b0; rst = 1'b0;
    chk("rst+out hs idle", in_ready & ~out_valid & ~busy, 1);
    chk("rst+out hs xyz", x_out | y_out | z_out, 0);

    // Reset coinciding with an accept: nothing captured, nothing produced.
    mode = 1; x_in = 12345; y_in = 777; z_in = -5; in_valid = 1'b1; rst = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b0;
    chk("rst+accept idle", in_ready & ~busy, 1);
    chk("rst+accept xyz", x_out | y_out | z_out, 0);
    bad = 1'b0;
    repeat (22) begin
      tick();
      if (out_valid || busy) bad = 1'b1;
    end
    chk("rst+accept no op", bad, 0);

    // Back-to-back throughput with in_valid and out_ready held high.
    mode = 0; x_in = 79135; y_in = 0; z_in = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid) rises.push_back(k);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("throughput count", rises.size() >= 2, 1);
    if (rises.size() >= 2) chk("throughput period", rises[1] - rises[0], 20);

    // Random operations against the reference model.
    for (int r = 0; r < 12; r++) begin
      bit m;
      int a, b, c;
      m = $urandom_range(0, 1);
      a = $urandom; b = $urandom; c = $urandom;
      if (r < 6) begin
        a = $urandom_range(0, 200000);
        b = int'($urandom_range(0, 200000)) - 100000;
        c = int'($urandom_range(0, 100000)) - 50000;
      end
      run_op(m, a, b, c, 1'b1, xo, yo, zo, lat);
      model(m, a, b, c, mx, my, mz);
      chk($sformatf("rand%0d latency", r), lat, 18);
      chk($sformatf("rand%0d x", r), xo, mx);
      chk($sformatf("rand%0d y", r), yo, my);
      chk($sformatf("rand%0d z", r), zo, mz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
